// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - shared types, region map and decode helpers for the ROM load sequencer
package rom_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        RUN
    } state_t;

    localparam int REGION_COUNT = 4;
    localparam int ADDR_W       = 25;
    localparam int ROM_ADDR_W   = 13;
    localparam int COUNT_W      = 17;

    localparam logic [ADDR_W-1:0] PROG_BASE      = 25'h0000;
    localparam logic [ADDR_W-1:0] PF_GFX_BASE    = 25'h2000;
    localparam logic [ADDR_W-1:0] CAR_GFX_BASE   = 25'h2800;
    localparam logic [ADDR_W-1:0] SYNC_PROM_BASE = 25'h2A00;

    localparam int PROG_SIZE      = 8192;
    localparam int PF_GFX_SIZE    = 2048;
    localparam int CAR_GFX_SIZE   = 512;
    localparam int SYNC_PROM_SIZE = 256;

    localparam logic [ADDR_W-1:0] IMAGE_END = 25'h2B00;

    function automatic logic [REGION_COUNT-1:0] region_of(input logic [ADDR_W-1:0] addr);
        logic [REGION_COUNT-1:0] r;
        r = '0;
        if (addr < PF_GFX_BASE)         r = 4'b0001;
        else if (addr < CAR_GFX_BASE)   r = 4'b0010;
        else if (addr < SYNC_PROM_BASE) r = 4'b0100;
        else if (addr < IMAGE_END)      r = 4'b1000;
        return r;
    endfunction

    // Bases reduced modulo the 13-bit local address space; the offset is
    // computed in that space, so the upper address bits never matter.
    function automatic logic [ROM_ADDR_W-1:0] region_base(input logic [REGION_COUNT-1:0] region);
        logic [ROM_ADDR_W-1:0] b;
        case (region)
            4'b0010: b = PF_GFX_BASE[ROM_ADDR_W-1:0];
            4'b0100: b = CAR_GFX_BASE[ROM_ADDR_W-1:0];
            4'b1000: b = SYNC_PROM_BASE[ROM_ADDR_W-1:0];
            default: b = PROG_BASE[ROM_ADDR_W-1:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_load_sequencer_if.sv
// rtl/rom_load_sequencer_if.sv - ioctl download stream in, ROM write port and status out
interface rom_load_sequencer_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_we;
    logic        core_reset_n;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_count;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_addr, rom_data, rom_we, core_reset_n, load_done, load_err, byte_count
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_addr, rom_data, rom_we, core_reset_n, load_done, load_err, byte_count
    );

endinterface

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - flat image address to one-hot region and region-local offset
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [ADDR_W-1:0]       addr,
    output logic [REGION_COUNT-1:0] region,
    output logic [ROM_ADDR_W-1:0]   offset
);

    always_comb begin
        region = region_of(addr);
        offset = addr[ROM_ADDR_W-1:0] - region_base(region);
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - steers an HPS ROM download into core ROM regions and gates core reset
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int TOTAL_BYTES = 11008,
    parameter int HOLD_CYCLES = 1024,
    parameter int CHECK_ORDER = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_load_sequencer_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0]  TOTAL_ADDR  = ADDR_W'(TOTAL_BYTES);
    localparam logic [COUNT_W-1:0] TOTAL_COUNT = COUNT_W'(TOTAL_BYTES);
    localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

    state_t                  state;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [ROM_ADDR_W-1:0]   rom_addr_q;
    logic [7:0]              rom_data_q;
    logic [REGION_COUNT-1:0] rom_we_q;
    logic                    core_reset_n_q;
    logic                    load_done_q;
    logic                    load_err_q;
    logic [COUNT_W-1:0]      byte_count_q;

    logic [REGION_COUNT-1:0] dec_region;
    logic [ROM_ADDR_W-1:0]   dec_offset;
    logic                    in_range;
    logic                    out_of_order;
    logic                    hold_expired;

    rom_region_decode u_decode (
        .addr   (bus.ioctl_addr),
        .region (dec_region),
        .offset (dec_offset)
    );

    always_comb begin
        in_range     = bus.ioctl_addr < TOTAL_ADDR;
        out_of_order = (CHECK_ORDER != 0) && (bus.ioctl_addr != {8'd0, byte_count_q});
        hold_expired = (HOLD_CYCLES == 0) || (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            rom_addr_q     <= '0;
            rom_data_q     <= '0;
            rom_we_q       <= '0;
            core_reset_n_q <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            byte_count_q   <= '0;
        end else begin
            rom_we_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.ioctl_download) begin
                        state        <= LOAD;
                        byte_count_q <= '0;
                        load_err_q   <= 1'b0;
                        load_done_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    // A strobe coinciding with the falling download edge still lands.
                    if (bus.ioctl_wr) begin
                        rom_addr_q <= dec_offset;
                        rom_data_q <= bus.ioctl_dout;
                        rom_we_q   <= in_range ? dec_region : '0;
                        if (byte_count_q != COUNT_MAX)
                            byte_count_q <= byte_count_q + 1'b1;
                        if (!in_range || out_of_order)
                            load_err_q <= 1'b1;
                    end
                    if (!bus.ioctl_download)
                        state <= CHECK;
                end
                CHECK: begin
                    hold_cnt <= '0;
                    if (byte_count_q != TOTAL_COUNT)
                        load_err_q <= 1'b1;
                    if (byte_count_q != TOTAL_COUNT || load_err_q) begin
                        load_done_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_expired) begin
                        state          <= RUN;
                        load_done_q    <= 1'b1;
                        core_reset_n_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Core goes back into reset before the first new byte can be written.
                    if (bus.ioctl_download) begin
                        state          <= LOAD;
                        core_reset_n_q <= 1'b0;
                        byte_count_q   <= '0;
                        load_err_q     <= 1'b0;
                        load_done_q    <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    core_reset_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_data     = rom_data_q;
    assign bus.rom_we       = rom_we_q;
    assign bus.core_reset_n = core_reset_n_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.byte_count   = byte_count_q;

endmodule
